// File: rtl/imem_fetch_master.sv
// AXI4-Lite instruction fetch master: one outstanding read, flush discards stale data.
// Optional IMEM_FETCH_ERR_CHECK_EN: non-OKAY RRESP yields a NOP and a fault pulse.
module imem_fetch_master (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        fetch_en_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] ARADDR,
  output logic [2:0]  ARPROT,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        fault_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fault_q, fault_d;

  logic issue;
  logic r_hs;
  logic r_keep;
  logic r_err;

  assign issue  = fetch_en_i & ~stall_i;
  // Stale responses must drain even while the pipeline is stalled.
  assign RREADY = (state_q == ST_DATA) & (~stall_i | discard_q | flush_i);
  assign r_hs   = RVALID & RREADY;
  assign r_keep = r_hs & ~discard_q & ~flush_i;

`ifdef IMEM_FETCH_ERR_CHECK_EN
  assign r_err = (RRESP != 2'b00);
`else
  // Response status is deliberately ignored in this build.
  assign r_err = (|RRESP) & 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    araddr_d     = araddr_q;
    inst_valid_d = r_keep;
    fault_d      = r_keep & r_err;
    inst_d       = inst_q;
    if (r_keep) inst_d = r_err ? NOP : RDATA;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d  = ST_ADDR;
          araddr_d = pc_i & ~32'h3;
        end
      end
      ST_ADDR: begin
        if (flush_i) discard_d = 1'b1;
        if (ARREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (r_hs) begin
          discard_d = 1'b0;
          if (issue) begin
            state_d  = ST_ADDR;
            araddr_d = pc_i & ~32'h3;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      discard_q    <= 1'b0;
      araddr_q     <= '0;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      araddr_q     <= araddr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign ARADDR       = araddr_q;
  assign ARPROT       = 3'b100;
  assign ARVALID      = (state_q == ST_ADDR);
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_imem_fetch_master.sv
// Scoreboard bench for imem_fetch_master with a reactive AXI4-Lite memory model.
module tb_imem_fetch_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        fetch_en_i, stall_i, flush_i;
  logic [31:0] pc_i;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID, RREADY;
  logic [31:0] inst_o;
  logic        inst_valid_o, fault_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] inst;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  imem_fetch_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .fetch_en_i(fetch_en_i), .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .fault_o(fault_o)
  );

  always #5 ACLK = ~ACLK;

  // Memory model: ARREADY after ar_wait cycles, RVALID r_wait cycles after the AR handshake.
  int unsigned ar_wait = 0, r_wait = 0, wcnt = 0, rcnt = 0;
  logic        pending  = 1'b0;
  logic        mem_kill = 1'b0;
  logic [1:0]  resp_cfg = 2'b00;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h000: return 32'h0010_0093;
      32'h004: return 32'h0020_0113;
      32'h008: return 32'h0030_0193;
      32'h00C: return 32'h0040_0213;
      32'h040: return 32'hDEAD_BEEF;
      32'h080: return 32'h0050_0093;
      32'h100: return 32'h0060_0313;
      32'h200: return 32'h0070_0393;
      default: return 32'hBAD0_BAD0;
    endcase
  endfunction

  assign ARREADY = ARVALID && (wcnt == ar_wait);
  assign RVALID  = pending && (rcnt == r_wait);

  always @(posedge ACLK) begin
    if (mem_kill) begin
      pending <= 1'b0;
      wcnt    <= 0;
    end else begin
      if (ARVALID && !ARREADY) wcnt <= wcnt + 1;
      if (RVALID && RREADY) pending <= 1'b0;
      else if (pending && rcnt != r_wait) rcnt <= rcnt + 1;
      if (ARVALID && ARREADY) begin
        wcnt    <= 0;
        pending <= 1'b1;
        rcnt    <= 0;
        RDATA   <= mem_data(ARADDR);
        RRESP   <= resp_cfg;
      end
    end
  end

  // Monitor: every delivered instruction must match the head of the scoreboard.
  always @(negedge ACLK) begin
    if (ARESETn === 1'b1 && inst_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: inst_o=%h fault_o=%b, no delivery expected", inst_o, fault_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (inst_o !== e.inst || fault_o !== e.fault) begin
          failures++;
          $display("FAIL delivery: got inst=%h fault=%b, expected inst=%h fault=%b",
                   inst_o, fault_o, e.inst, e.fault);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic fault);
    exp_t e;
    e.inst  = inst;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, {31'd0, ARVALID}, 32'd0);
    chk({tag, "_araddr"}, ARADDR, 32'h0);
    chk({tag, "_arprot"}, {29'd0, ARPROT}, 32'd4);
    chk({tag, "_rready"}, {31'd0, RREADY}, 32'd0);
    chk({tag, "_inst"}, inst_o, 32'h0000_0013);
    chk({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault_o}, 32'd0);
  endtask

  initial begin
    ARESETn = 1'b0; fetch_en_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; pc_i = '0;
    #12;
    chk_reset_outputs("rst");
    tick();
    ARESETn = 1'b1;
    tick();

    // Back-to-back zero-wait fetches 0x0, 0x4, 0x8.
    fetch_en_i = 1'b1; pc_i = 32'h0; push(32'h0010_0093, 1'b0);
    tick();
    chk("b2b_arvalid0", {31'd0, ARVALID}, 32'd1);
    chk("b2b_araddr0", ARADDR, 32'h0);
    pc_i = 32'h4; push(32'h0020_0113, 1'b0);
    tick();
    chk("b2b_ar_held1", {31'd0, ARVALID}, 32'd0);
    chk("b2b_rready", {31'd0, RREADY}, 32'd1);
    tick();
    chk("b2b_araddr4", ARADDR, 32'h4);
    chk("b2b_arvalid4", {31'd0, ARVALID}, 32'd1);
    chk("b2b_pulse0", {31'd0, inst_valid_o}, 32'd1);
    pc_i = 32'h8; push(32'h0030_0193, 1'b0);
    tick();
    chk("b2b_gap", {31'd0, inst_valid_o}, 32'd0);
    tick();
    chk("b2b_araddr8", ARADDR, 32'h8);
    chk("b2b_pulse1", {31'd0, inst_valid_o}, 32'd1);
    fetch_en_i = 1'b0;
    tick();
    tick();
    chk("b2b_pulse2", {31'd0, inst_valid_o}, 32'd1);
    chk("b2b_idle", {31'd0, ARVALID}, 32'd0);
    tick();

    // AR backpressure for 3 cycles with flush in the 2nd; jump target then delivered.
    ar_wait = 3; pc_i = 32'h40; fetch_en_i = 1'b1;
    tick();
    fetch_en_i = 1'b0;
    chk("bp_arvalid1", {31'd0, ARVALID}, 32'd1);
    chk("bp_araddr1", ARADDR, 32'h40);
    chk("bp_arready1", {31'd0, ARREADY}, 32'd0);
    tick();
    chk("bp_araddr2", ARADDR, 32'h40);
    flush_i = 1'b1; pc_i = 32'h100;
    tick();
    flush_i = 1'b0;
    chk("bp_arvalid3", {31'd0, ARVALID}, 32'd1);
    chk("bp_araddr3", ARADDR, 32'h40);
    chk("bp_arready3", {31'd0, ARREADY}, 32'd0);
    tick();
    chk("bp_arready4", {31'd0, ARREADY}, 32'd1);
    fetch_en_i = 1'b1;
    tick();
    ar_wait = 0; push(32'h0060_0313, 1'b0);
    tick();
    chk("bp_dropped", {31'd0, inst_valid_o}, 32'd0);
    chk("bp_jump_addr", ARADDR, 32'h100);
    fetch_en_i = 1'b0;
    tick();
    tick();
    chk("bp_jump_pulse", {31'd0, inst_valid_o}, 32'd1);
    tick();

    // Stall holds off RREADY while RVALID is up.
    pc_i = 32'hC; fetch_en_i = 1'b1; push(32'h0040_0213, 1'b0);
    tick();
    fetch_en_i = 1'b0;
    tick();
    stall_i = 1'b1;
    #1;
    chk("stall_rvalid", {31'd0, RVALID}, 32'd1);
    chk("stall_rready", {31'd0, RREADY}, 32'd0);
    tick();
    chk("stall_nopulse", {31'd0, inst_valid_o}, 32'd0);
    stall_i = 1'b0;
    #1;
    chk("unstall_rready", {31'd0, RREADY}, 32'd1);
    tick();
    chk("unstall_pulse", {31'd0, inst_valid_o}, 32'd1);
    tick();

    // Flush in the same cycle as the R handshake drops the response.
    pc_i = 32'h80; fetch_en_i = 1'b1;
    tick();
    fetch_en_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("sameflush_nopulse", {31'd0, inst_valid_o}, 32'd0);
    chk("sameflush_inst_hold", inst_o, 32'h0040_0213);
    tick();

    // Flush while idle has no effect on the next request.
    pc_i = 32'h4; fetch_en_i = 1'b1; flush_i = 1'b1; push(32'h0020_0113, 1'b0);
    tick();
    fetch_en_i = 1'b0; flush_i = 1'b0;
    chk("idleflush_araddr", ARADDR, 32'h4);
    tick();
    tick();
    chk("idleflush_pulse", {31'd0, inst_valid_o}, 32'd1);
    tick();

    // Error response.
    resp_cfg = 2'b10; pc_i = 32'h200; fetch_en_i = 1'b1;
`ifdef IMEM_FETCH_ERR_CHECK_EN
    push(32'h0000_0013, 1'b1);
`else
    push(32'h0070_0393, 1'b0);
`endif
    tick();
    fetch_en_i = 1'b0;
    tick();
    tick();
    chk("err_pulse", {31'd0, inst_valid_o}, 32'd1);
    resp_cfg = 2'b00;
    tick();
    chk("err_fault_1cyc", {31'd0, fault_o}, 32'd0);

    // Reset while waiting in DATA; late response must not be forwarded.
    r_wait = 4; pc_i = 32'h0; fetch_en_i = 1'b1;
    tick();
    fetch_en_i = 1'b0;
    tick();
    tick();
    ARESETn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    ARESETn = 1'b1;
    for (int i = 0; i < 10 && RVALID !== 1'b1; i++) tick();
    chk("late_rvalid_seen", {31'd0, RVALID}, 32'd1);
    chk("late_rready", {31'd0, RREADY}, 32'd0);
    tick();
    tick();
    chk("late_nopulse", {31'd0, inst_valid_o}, 32'd0);
    mem_kill = 1'b1;
    tick();
    mem_kill = 1'b0; r_wait = 0;
    tick();
    tick();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
